// File: rtl/puf_pkg.sv
// Shared types and timing constants for the ring-oscillator PUF controller.
package puf_pkg;

    localparam int unsigned CLR_CYC    = 2;
    localparam int unsigned SETTLE_CYC = 3;
    localparam int unsigned TMR_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } puf_state_e;

    // Cycles spent on one response bit for a given oscillator window.
    function automatic int unsigned bit_period(input int unsigned window);
        return window + CLR_CYC + SETTLE_CYC + 1;
    endfunction

endpackage

// File: rtl/puf_cnt_sync.sv
// Two-flop vector synchronizer for oscillator counts; counts are frozen
// while this settles, so no per-bit coherency scheme is needed.
module puf_cnt_sync #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;

    // Two-stage capture of the oscillator-domain count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/puf_challenge_ctrl.sv
// Challenge sequencer for the RO PUF: clear, run, settle and compare the
// two oscillator banks once per challenge, assembling an N_BITS response.
module puf_challenge_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned CHAL_W = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WINDOW = 64,
    parameter int unsigned N_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CHAL_W-1:0] seed,
    input  logic [CNT_W-1:0]  count_a,
    input  logic [CNT_W-1:0]  count_b,
    output logic [CHAL_W-1:0] chal,
    output logic              osc_en,
    output logic              cnt_clr,
    output logic              busy,
    output logic [N_BITS-1:0] resp,
    output logic              resp_valid
);

    localparam int unsigned K_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    puf_state_e        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CHAL_W-1:0] chal_d;
    logic [N_BITS-1:0] resp_d;
    logic              osc_en_d, cnt_clr_d, busy_d, resp_valid_d;
    logic [CNT_W-1:0]  cnt_a_s, cnt_b_s;
    logic              a_gt_b_c;

    puf_cnt_sync #(.W(CNT_W)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (count_a),
        .q     (cnt_a_s)
    );

    puf_cnt_sync #(.W(CNT_W)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (count_b),
        .q     (cnt_b_s)
    );

    // Strict greater-than: a tie yields a 0 response bit.
    assign a_gt_b_c = (cnt_a_s > cnt_b_s);

    // State, timer, index and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            k_q        <= '0;
            chal       <= '0;
            resp       <= '0;
            osc_en     <= 1'b0;
            cnt_clr    <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            k_q        <= k_d;
            chal       <= chal_d;
            resp       <= resp_d;
            osc_en     <= osc_en_d;
            cnt_clr    <= cnt_clr_d;
            busy       <= busy_d;
            resp_valid <= resp_valid_d;
        end
    end

    // Next state and next output values; outputs describe the next cycle.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        k_d          = k_q;
        chal_d       = chal;
        resp_d       = resp;
        osc_en_d     = 1'b0;
        cnt_clr_d    = 1'b0;
        busy_d       = 1'b1;
        resp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d   = ST_CLEAR;
                    chal_d    = seed;
                    k_d       = '0;
                    resp_d    = '0;
                    tmr_d     = TMR_W'(CLR_CYC - 1);
                    cnt_clr_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (tmr_q == '0) begin
                    state_d  = ST_RUN;
                    tmr_d    = TMR_W'(WINDOW - 1);
                    osc_en_d = 1'b1;
                end else begin
                    tmr_d     = tmr_q - TMR_W'(1);
                    cnt_clr_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (tmr_q == '0) begin
                    state_d = ST_SETTLE;
                    tmr_d   = TMR_W'(SETTLE_CYC - 1);
                end else begin
                    tmr_d    = tmr_q - TMR_W'(1);
                    osc_en_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_CAPTURE: begin
                // resp was zeroed at start, so OR-ing the new bit in is enough.
                resp_d = resp | (N_BITS'(a_gt_b_c) << k_q);
                if (k_q == K_W'(N_BITS - 1)) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d   = ST_CLEAR;
                    k_d       = k_q + K_W'(1);
                    chal_d    = chal + CHAL_W'(1);
                    tmr_d     = TMR_W'(CLR_CYC - 1);
                    cnt_clr_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort cancels everything except the partial response and challenge.
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            tmr_d        = tmr_q;
            k_d          = k_q;
            chal_d       = chal;
            resp_d       = resp;
            osc_en_d     = 1'b0;
            cnt_clr_d    = 1'b0;
            busy_d       = 1'b0;
            resp_valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Directed bench for puf_challenge_ctrl: a WINDOW=16/N_BITS=4 instance and a
// WINDOW=1/N_BITS=1 instance sharing one clock.
module tb_puf_challenge_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [3:0] seed;
    logic [7:0] count_a, count_b;
    logic [3:0] chal;
    logic       osc_en, cnt_clr, busy, resp_valid;
    logic [3:0] resp;

    logic       start2, abort2;
    logic [3:0] seed2;
    logic [7:0] count_a2, count_b2;
    logic [3:0] chal2;
    logic       osc_en2, cnt_clr2, busy2, resp_valid2;
    logic [0:0] resp2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    puf_challenge_ctrl #(.CHAL_W(4), .CNT_W(8), .WINDOW(16), .N_BITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .seed       (seed),
        .count_a    (count_a),
        .count_b    (count_b),
        .chal       (chal),
        .osc_en     (osc_en),
        .cnt_clr    (cnt_clr),
        .busy       (busy),
        .resp       (resp),
        .resp_valid (resp_valid)
    );

    puf_challenge_ctrl #(.CHAL_W(4), .CNT_W(8), .WINDOW(1), .N_BITS(1)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .abort      (abort2),
        .seed       (seed2),
        .count_a    (count_a2),
        .count_b    (count_b2),
        .chal       (chal2),
        .osc_en     (osc_en2),
        .cnt_clr    (cnt_clr2),
        .busy       (busy2),
        .resp       (resp2),
        .resp_valid (resp_valid2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int cyc,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One full 4-bit run on dut; expectations come from the 22-cycle bit
    // timeline (CLEAR 0-1, RUN 2-17, SETTLE 18-20, CAPTURE 21).
    task automatic run_check(input logic [3:0] sd, input logic [31:0] ca_p,
                             input logic [31:0] cb_p, input logic [3:0] exp_resp,
                             input int glitch_cyc);
        int b, p, osc_cnt, clr_cnt;
        logic [3:0] echal;
        logic [3:0] emask;
        osc_cnt = 0;
        clr_cnt = 0;
        seed    = sd;
        count_a = ca_p[7:0];
        count_b = cb_p[7:0];
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int c = 1; c <= 90; c++) begin
            if (c <= 88) begin
                b = (c - 1) / 22;
                p = (c - 1) % 22;
                echal = sd + 4'(b);
                check("busy", c, 32'(busy), 32'd1);
                check("cnt_clr", c, 32'(cnt_clr), 32'((p < 2) ? 1 : 0));
                check("osc_en", c, 32'(osc_en), 32'((p >= 2 && p < 18) ? 1 : 0));
                check("resp_valid", c, 32'(resp_valid), 32'd0);
                check("chal", c, 32'(chal), 32'(echal));
                if (p == 0) begin
                    emask = 4'((32'd1 << b) - 1);
                    check("resp_partial", c, 32'(resp), 32'(exp_resp & emask));
                    count_a = ca_p[b*8 +: 8];
                    count_b = cb_p[b*8 +: 8];
                end
            end else if (c == 89) begin
                check("busy_done", c, 32'(busy), 32'd1);
                check("resp_valid_done", c, 32'(resp_valid), 32'd1);
                check("osc_en_done", c, 32'(osc_en), 32'd0);
                check("resp_done", c, 32'(resp), 32'(exp_resp));
                check("chal_done", c, 32'(chal), 32'(4'(sd + 4'd3)));
            end else begin
                check("busy_after", c, 32'(busy), 32'd0);
                check("resp_valid_after", c, 32'(resp_valid), 32'd0);
                check("resp_hold", c, 32'(resp), 32'(exp_resp));
            end
            osc_cnt += int'(osc_en);
            clr_cnt += int'(cnt_clr);
            start = (c == glitch_cyc);
            step();
        end
        start = 1'b0;
        check("osc_en_total", 0, 32'(osc_cnt), 32'd64);
        check("cnt_clr_total", 0, 32'(clr_cnt), 32'd8);
    endtask

    initial begin
        int vcnt;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        seed     = 4'h0;
        count_a  = 8'h0;
        count_b  = 8'h0;
        start2   = 1'b0;
        abort2   = 1'b0;
        seed2    = 4'h0;
        count_a2 = 8'h0;
        count_b2 = 8'h0;
        step();
        step();
        check("rst_chal", 0, 32'(chal), 32'd0);
        check("rst_osc_en", 0, 32'(osc_en), 32'd0);
        check("rst_cnt_clr", 0, 32'(cnt_clr), 32'd0);
        check("rst_busy", 0, 32'(busy), 32'd0);
        check("rst_resp", 0, 32'(resp), 32'd0);
        check("rst_resp_valid", 0, 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic: a>b on every bit, chal walks E,F,0,1.
        run_check(4'hE, 32'h40404040, 32'h3F3F3F3F, 4'hF, -1);
        // Tie on bits 0/1, loss on bits 2/3.
        run_check(4'h5, 32'h10102020, 32'h80802020, 4'h0, -1);
        // Mixed 1,0,1,1 with a start pulse mid-run that must be ignored.
        run_check(4'h2, 32'h50501050, 32'h30306030, 4'hD, 30);

        // Abort during RUN of bit 2 (cycle 50 is phase 5 of bit 2).
        seed    = 4'h3;
        count_a = 8'h05;
        count_b = 8'h01;
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int c = 1; c < 50; c++) step();
        check("abort_pre_osc_en", 50, 32'(osc_en), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 51, 32'(busy), 32'd0);
        check("abort_osc_en", 51, 32'(osc_en), 32'd0);
        check("abort_cnt_clr", 51, 32'(cnt_clr), 32'd0);
        check("abort_resp", 51, 32'(resp), 32'h3);
        check("abort_chal", 51, 32'(chal), 32'h5);
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            vcnt += int'(resp_valid) + int'(busy);
            step();
        end
        check("abort_quiet", 0, 32'(vcnt), 32'd0);

        // Start and abort together in IDLE: start wins.
        seed  = 4'h7;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_wins_busy", 1, 32'(busy), 32'd1);
        check("start_wins_clr", 1, 32'(cnt_clr), 32'd1);
        // Reset asserted in SETTLE of bit 0 (cycle 20).
        for (int c = 1; c < 20; c++) step();
        check("pre_rst_chal", 20, 32'(chal), 32'h7);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_chal", 20, 32'(chal), 32'd0);
        check("arst_busy", 20, 32'(busy), 32'd0);
        check("arst_osc_en", 20, 32'(osc_en), 32'd0);
        check("arst_cnt_clr", 20, 32'(cnt_clr), 32'd0);
        check("arst_resp", 20, 32'(resp), 32'd0);
        check("arst_resp_valid", 20, 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_check(4'h9, 32'h01020304, 32'h02020202, 4'h3, -1);

        // Single-bit, single-cycle-window instance.
        seed2    = 4'hA;
        count_a2 = 8'h09;
        count_b2 = 8'h03;
        start2   = 1'b1;
        step();
        start2   = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check("n1_chal", c, 32'(chal2), 32'hA);
            check("n1_resp_valid", c, 32'(resp_valid2), 32'((c == 8) ? 1 : 0));
            check("n1_busy", c, 32'(busy2), 32'((c <= 8) ? 1 : 0));
            check("n1_osc_en", c, 32'(osc_en2), 32'((c == 3) ? 1 : 0));
            check("n1_cnt_clr", c, 32'(cnt_clr2), 32'((c <= 2) ? 1 : 0));
            if (c >= 8) check("n1_resp", c, 32'(resp2), 32'd1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_challenge_ctrl.md
# puf_challenge_ctrl

Measurement controller for the ring-oscillator PUF: the challenge-issuing end of the oscillator/counter/comparator datapath. On `start` it walks a sequence of challenges and, for each one, clears the oscillator counters, enables the oscillators for a fixed window, freezes them, samples both counts and records one response bit. After `N_BITS` challenges it presents the response word with a one-cycle valid pulse. It sits between the tile I/O and the two oscillator banks.

## Interface
- `CHAL_W`, 4: challenge (oscillator select) width.
- `CNT_W`, 8: oscillator counter width.
- `WINDOW`, 64: cycles `osc_en` stays high per challenge, range 1..2^16-1.
- `N_BITS`, 16: response bits per run, range 1..32.

- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous and active-low.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: cancel the run in progress.
- `seed` in CHAL_W: first challenge, latched on accepted `start`.
- `count_a` in CNT_W: bank A counter value (oscillator domain).
- `count_b` in CNT_W: bank B counter value (oscillator domain).
- `chal` out CHAL_W: challenge driven to both bank muxes.
- `osc_en` out 1: oscillator enable.
- `cnt_clr` out 1: counter clear, active-high.
- `busy` out 1: high in every state except IDLE.
- `resp` out N_BITS: response word.
- `resp_valid` out 1: single-cycle pulse when `resp` is complete.

## Operation
- FSM states: IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE.
- IDLE -> CLEAR on `start`. Latch `seed` into `chal`, zero the bit index `k`, and zero `resp`.
- CLEAR: `cnt_clr`=1 for CLR_CYC=2 cycles, `osc_en`=0. Then go to RUN.
- RUN: `osc_en`=1 for exactly WINDOW cycles, `cnt_clr`=0. Then go to SETTLE.
- SETTLE: `osc_en`=0 for SETTLE_CYC=3 cycles. Counts are frozen and pass through a 2-flop synchronizer. Then go to CAPTURE.
- CAPTURE (1 cycle): set `resp[k]` = 1 if synced `count_a` > synced `count_b`, else 0.
  - The comparison is unsigned, full CNT_W width.
  - A tie gives 0.
  - Counter wrap is not detected. The integrator sizes WINDOW so counts do not wrap.
- After CAPTURE:
  - If `k` == N_BITS-1, go to DONE.
  - Otherwise increment `k`, set `chal` to `chal`+1 modulo 2^CHAL_W (wraps F->0), and go to CLEAR.
- DONE (1 cycle): `resp_valid`=1, then go to IDLE.
- `resp` holds its value in IDLE until the next accepted `start`.
- `start` while busy is ignored; no queuing.
- `abort` in any non-IDLE state: go to IDLE next cycle.
  - `osc_en` and `cnt_clr` are forced to 0 that cycle.
  - `resp_valid` is not asserted.
  - `resp` keeps its partial contents.
- `abort` and `start` together in IDLE: `start` wins; `abort` is ignored in IDLE.

## Timing
- All outputs are registered.
- Reset values: `chal`=0, `osc_en`=0, `cnt_clr`=0, `busy`=0, `resp`=0, `resp_valid`=0, state IDLE.
- Cycle 0 is the edge that samples `start`. In cycle 1, `busy`=1 and `cnt_clr`=1.
- Per-bit period is WINDOW+6 cycles: CLEAR 2 + RUN WINDOW + SETTLE 3 + CAPTURE 1.
- `resp_valid` is high in cycle N_BITS*(WINDOW+6)+1. `busy` drops in the following cycle.
- `chal` changes only on the CAPTURE->CLEAR transition, so it is stable for the whole CLEAR/RUN/SETTLE of its bit.
- Reset mid-run takes effect immediately (asynchronous): all outputs go to their reset values and oscillators stop.

## Structure
- `puf_pkg` holds:
  - the state enum;
  - `CLR_CYC`=2 and `SETTLE_CYC`=3;
  - the per-bit period function WINDOW+CLR_CYC+SETTLE_CYC+1.
- Sub-module `puf_cnt_sync`: a 2-flop synchronizer for the CNT_W-wide counts, instantiated once per bank. The counts are quasi-static during SETTLE, so a plain vector sync is sufficient.
- Timers: one shared down-counter, 16 bits, reloaded on each state entry.

## Test plan
- Basic run: WINDOW=16, N_BITS=4, seed=4'hE, `count_a`=8'h40, `count_b`=8'h3F.
  - `chal` sequence E,F,0,1 (wrap checked).
  - `resp`=4'hF.
  - `resp_valid` at cycle 89, single cycle.
- Tie and loss: `count_a`=`count_b`=8'h20 for bits 0 and 1, then `count_a`=8'h10, `count_b`=8'h80 for bits 2 and 3 -> `resp`=4'h0.
- Mixed pattern: model swaps which bank is larger per challenge so the pattern is 1,0,1,1 -> `resp`=4'hD. Also check `cnt_clr` is 2 cycles and `osc_en` is exactly 16 cycles per bit.
- `abort` asserted in RUN of bit 2 -> next cycle IDLE, `osc_en`=0, `busy`=0, no `resp_valid`, `resp[1:0]` retained.
- `start` pulsed mid-run is ignored, so completion stays at cycle 89. `rst_n` low in SETTLE -> all outputs zero asynchronously, and the next `start` runs cleanly.
- N_BITS=1, WINDOW=1 -> `resp_valid` at cycle 8, `chal`=`seed` throughout.
